// File: rtl/cvxif_instr_pkg.sv
// Shared types for the CV-X-IF issue tracker: decode table entries, the default
// coprocessor instruction table and the head-of-buffer FSM states.
package cvxif_instr_pkg;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   mask;
    x_issue_resp_t resp;
  } copro_issue_resp_t;

  localparam int unsigned CoproNbInstr = 4;

  // Index 0 sits in the rightmost slot; entry 3 is a catch-all for other custom0
  // encodings and only wins when none of the more specific entries match.
  localparam copro_issue_resp_t [CoproNbInstr-1:0] CoproInstr = {
    copro_issue_resp_t'({32'h0000_000B, 32'h0000_007F, 6'b000001}),
    copro_issue_resp_t'({32'h0000_002B, 32'h0000_007F, 6'b110100}),
    copro_issue_resp_t'({32'h0000_100B, 32'h0000_707F, 6'b100010}),
    copro_issue_resp_t'({32'h0000_000B, 32'h0000_707F, 6'b110000})
  };

  typedef enum logic [1:0] {
    HEAD_IDLE,
    HEAD_EXEC,
    HEAD_RESULT
  } head_state_e;

  function automatic logic instr_match(input copro_issue_resp_t entry,
                                       input logic [31:0] instr);
    return (instr & entry.mask) == entry.instr;
  endfunction

endpackage

// File: rtl/cvxif_issue_fifo.sv
// In-order buffer of accepted instructions. Keeps commit/kill flags per entry and
// exposes per-entry id/valid for duplicate-id rejection and commit matching.
module cvxif_issue_fifo #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned IdWidth   = 3,
  parameter type         payload_t = logic
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [IdWidth-1:0]            push_id_i,
  input  payload_t                      push_data_i,
  input  logic                          pop_i,
  input  logic                          mark_valid_i,
  input  logic [IdWidth-1:0]            mark_id_i,
  input  logic                          mark_kill_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [Depth-1:0]              entry_valid_o,
  output logic [Depth-1:0][IdWidth-1:0] entry_id_o,
  output logic [IdWidth-1:0]            head_id_o,
  output payload_t                      head_data_o,
  output logic                          head_committed_o,
  output logic                          head_killed_o
);

  localparam int unsigned AddrWidth = $clog2(Depth);

  logic [AddrWidth:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [AddrWidth-1:0]          wr_addr, rd_addr;
  logic [Depth-1:0]              committed_q, committed_d, killed_q, killed_d;
  logic [Depth-1:0][IdWidth-1:0] id_q, id_d;
  payload_t                      data_q [Depth];
  payload_t                      data_d [Depth];

  assign wr_addr          = wr_ptr_q[AddrWidth-1:0];
  assign rd_addr          = rd_ptr_q[AddrWidth-1:0];
  assign count            = wr_ptr_q - rd_ptr_q;
  assign full_o           = (count == (AddrWidth+1)'(Depth));
  assign empty_o          = (count == '0);
  assign entry_id_o       = id_q;
  assign head_id_o        = id_q[rd_addr];
  assign head_data_o      = data_q[rd_addr];
  assign head_committed_o = committed_q[rd_addr];
  assign head_killed_o    = killed_q[rd_addr];

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      entry_valid_o[i] = {1'b0, AddrWidth'(i) - rd_addr} < count;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    committed_d = committed_q;
    killed_d    = killed_q;
    id_d        = id_q;
    data_d      = data_q;
    if (mark_valid_i) begin
      for (int i = 0; i < Depth; i++) begin
        if (entry_valid_o[i] && (id_q[i] == mark_id_i) && !committed_q[i] && !killed_q[i]) begin
          committed_d[i] = !mark_kill_i;
          killed_d[i]    = mark_kill_i;
        end
      end
    end
    // A commit for the id being pushed this cycle lands directly in the new slot.
    if (push_i) begin
      data_d[wr_addr]      = push_data_i;
      id_d[wr_addr]        = push_id_i;
      committed_d[wr_addr] = mark_valid_i && (mark_id_i == push_id_i) && !mark_kill_i;
      killed_d[wr_addr]    = mark_valid_i && (mark_id_i == push_id_i) && mark_kill_i;
      wr_ptr_d             = wr_ptr_q + (AddrWidth+1)'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + (AddrWidth+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      committed_q <= '0;
      killed_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
    end
  end

  always_ff @(posedge clk_i) begin
    id_q   <= id_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/cvxif_issue_tracker.sv
// CV-X-IF coprocessor front end: table-driven issue decode, in-order tracking of
// accepted instructions until commit, fixed-latency execute and result return.
module cvxif_issue_tracker
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned                       NbInstr    = 4,
  parameter copro_issue_resp_t [NbInstr-1:0]   InstrTable = CoproInstr,
  parameter int unsigned                       Depth      = 4,
  parameter int unsigned                       IdWidth    = 3,
  parameter int unsigned                       XLEN       = 32,
  parameter int unsigned                       Latency    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic [5:0]         issue_resp_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o
);

  typedef struct packed {
    logic [4:0]      rd;
    logic            writeback;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } payload_t;

  // The IDLE cycle that sees the committed head counts as the first execute cycle,
  // so EXEC itself runs Latency-1 cycles, never fewer than one.
  localparam logic [3:0] ExecLoad = (Latency > 0) ? 4'(Latency - 1) : 4'd0;

  x_issue_resp_t                 dec_resp, resp;
  logic                          dup_id, push, pop, full, empty;
  logic [Depth-1:0]              entry_valid;
  logic [Depth-1:0][IdWidth-1:0] entry_id;
  logic [IdWidth-1:0]            head_id;
  payload_t                      push_data, head_data;
  logic                          head_committed, head_killed;
  head_state_e                   state_q, state_d;
  logic [3:0]                    cnt_q, cnt_d;

  // Walk the table from the top so the lowest matching index is written last.
  always_comb begin
    dec_resp = '0;
    for (int i = int'(NbInstr) - 1; i >= 0; i--) begin
      if (instr_match(InstrTable[i], issue_instr_i)) begin
        dec_resp = InstrTable[i].resp;
      end
    end
  end

  always_comb begin
    dup_id = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (entry_valid[i] && (entry_id[i] == issue_id_i)) begin
        dup_id = 1'b1;
      end
    end
  end

  always_comb begin
    resp        = dec_resp;
    resp.accept = dec_resp.accept && !full && !dup_id;
  end

  assign issue_ready_o = !full;
  assign issue_resp_o  = resp;
  assign push          = issue_valid_i && issue_ready_o && resp.accept;
  assign push_data     = '{rd: issue_instr_i[11:7], writeback: dec_resp.writeback,
                           rs1: issue_rs1_i, rs2: issue_rs2_i};

  cvxif_issue_fifo #(
    .Depth     (Depth),
    .IdWidth   (IdWidth),
    .payload_t (payload_t)
  ) i_fifo (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .push_i           (push),
    .push_id_i        (issue_id_i),
    .push_data_i      (push_data),
    .pop_i            (pop),
    .mark_valid_i     (commit_valid_i),
    .mark_id_i        (commit_id_i),
    .mark_kill_i      (commit_kill_i),
    .full_o           (full),
    .empty_o          (empty),
    .entry_valid_o    (entry_valid),
    .entry_id_o       (entry_id),
    .head_id_o        (head_id),
    .head_data_o      (head_data),
    .head_committed_o (head_committed),
    .head_killed_o    (head_killed)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      HEAD_IDLE: begin
        if (!empty) begin
          if (head_killed) begin
            pop = 1'b1;
          end else if (head_committed) begin
            state_d = HEAD_EXEC;
            cnt_d   = ExecLoad;
          end
        end
      end
      HEAD_EXEC: begin
        if (cnt_q <= 4'd1) begin
          cnt_d = '0;
          if (head_data.writeback) begin
            state_d = HEAD_RESULT;
          end else begin
            pop     = 1'b1;
            state_d = HEAD_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HEAD_RESULT: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = HEAD_IDLE;
        end
      end
      default: state_d = HEAD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HEAD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result_valid_o = (state_q == HEAD_RESULT);
  assign result_id_o    = result_valid_o ? head_id : '0;
  assign result_rd_o    = result_valid_o ? head_data.rd : '0;
  assign result_data_o  = result_valid_o ? (head_data.rs1 + head_data.rs2) : '0;

endmodule
